// File: rtl/grey_encoder_arbiter.sv
// grey_encoder_arbiter: round-robin shared Gray encoder with a one-entry registered output slot
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_en                global enable for new grants
//   i_req, i_bin        per-requester request and flattened binary values (requester r at [r*N +: N])
//   o_gnt               combinational one-hot grant
//   o_grey, o_id        registered Gray value and source requester index
//   o_valid, i_ready    output slot handshake
module grey_encoder_arbiter #(
   parameter int N    = 3,
   parameter int REQS = 4,
   parameter int ID_W = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [REQS-1:0]   i_req,
   input  logic [REQS*N-1:0] i_bin,
   output logic [REQS-1:0]   o_gnt,
   output logic [N-1:0]      o_grey,
   output logic [ID_W-1:0]   o_id,
   output logic              o_valid,
   input  logic              i_ready
);
   logic [N-1:0] bin [REQS];
   logic [ID_W-1:0] ptr, idx, gidx;
   logic grant_ok, found;
   logic [N-1:0] grey_next;
   for (genvar r = 0; r < REQS; r++) begin : g_bin
      assign bin[r] = i_bin[r*N +: N];
   end
   // gating on i_rst_n keeps o_gnt low during reset
   assign grant_ok = i_rst_n && i_en && (!o_valid || i_ready) && |i_req;
   // scan ptr+1, ptr+2, ... modulo REQS; first pending request wins
   always_comb begin
      o_gnt = '0;
      found = 1'b0;
      gidx = '0;
      idx = '0;
      for (int k = 1; k <= REQS; k++) begin
         idx = ID_W'((32'(ptr) + k) % REQS);
         if (grant_ok && !found && i_req[idx]) begin
            o_gnt[idx] = 1'b1;
            gidx = idx;
            found = 1'b1;
         end
      end
   end
   assign grey_next = bin[gidx] ^ (bin[gidx] >> 1);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_grey <= '0;
         o_id <= '0;
         ptr <= ID_W'(REQS - 1);
      end else if (found) begin
         o_valid <= 1'b1;
         o_grey <= grey_next;
         o_id <= gidx;
         ptr <= gidx;
      end else if (i_ready)
         o_valid <= 1'b0;
endmodule

// File: tb/tb_grey_encoder_arbiter.sv
// tb_grey_encoder_arbiter: directed self-checking bench for grey_encoder_arbiter
module tb_grey_encoder_arbiter;
   localparam int N = 3;
   localparam int REQS = 4;
   localparam int ID_W = 2;
   logic i_clk, i_rst_n, i_en, i_ready, o_valid;
   logic [REQS-1:0] i_req, o_gnt;
   logic [REQS*N-1:0] i_bin;
   logic [N-1:0] o_grey;
   logic [ID_W-1:0] o_id;
   int tests = 0;
   int fails = 0;

   grey_encoder_arbiter #(.N(N), .REQS(REQS), .ID_W(ID_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_req(i_req), .i_bin(i_bin),
      .o_gnt(o_gnt), .o_grey(o_grey), .o_id(o_id), .o_valid(o_valid), .i_ready(i_ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic set_bin(input int r, input logic [N-1:0] v);
      i_bin[r*N +: N] = v;
   endtask

   task automatic test_reset;
      i_req = 4'b1111;
      #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      tests++; if (o_grey !== 3'b000) begin fails++; $display("FAIL reset_grey: got %b want 000", o_grey); end
      tests++; if (o_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", o_id); end
      tests++; if (o_gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", o_gnt); end
      @(negedge i_clk);
      i_req = '0;
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic test_single;
      @(negedge i_clk);
      i_req = 4'b0001; set_bin(0, 3'b101);
      #1;
      tests++; if (o_gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b want 0001", o_gnt); end
      @(posedge i_clk); #1;
      i_req = '0;
      tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", o_valid); end
      tests++; if (o_grey !== 3'b111) begin fails++; $display("FAIL single_grey: got %b want 111", o_grey); end
      tests++; if (o_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d want 0", o_id); end
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", o_valid); end
   endtask

   task automatic test_exhaustive;
      logic [N-1:0] exp_g [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      for (int v = 0; v < 8; v++) begin
         @(negedge i_clk);
         i_req = 4'b0010; set_bin(1, 3'(v));
         #1;
         tests++; if (o_gnt !== 4'b0010) begin fails++; $display("FAIL exh_gnt[%0d]: got %b want 0010", v, o_gnt); end
         @(posedge i_clk); #1;
         tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL exh_valid[%0d]: got %b want 1", v, o_valid); end
         tests++; if (o_grey !== exp_g[v]) begin fails++; $display("FAIL exh_grey[%0d]: got %b want %b", v, o_grey, exp_g[v]); end
         tests++; if (o_id !== 2'd1) begin fails++; $display("FAIL exh_id[%0d]: got %0d want 1", v, o_id); end
      end
      @(negedge i_clk);
      i_req = '0;
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL exh_drain: got %b want 0", o_valid); end
   endtask

   task automatic test_backpressure;
      @(negedge i_clk);
      i_req = 4'b0100; set_bin(2, 3'b011);
      @(posedge i_clk); #1;
      tests++; if (o_grey !== 3'b010 || o_id !== 2'd2) begin fails++; $display("FAIL bp_load: got %b/%0d want 010/2", o_grey, o_id); end
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         i_ready = 1'b0; i_req = 4'b1111; set_bin(0, 3'b001); set_bin(1, 3'b010); set_bin(3, 3'b111);
         #1;
         tests++; if (o_gnt !== 4'b0000) begin fails++; $display("FAIL bp_gnt[%0d]: got %b want 0000", c, o_gnt); end
         @(posedge i_clk); #1;
         tests++; if (o_valid !== 1'b1 || o_grey !== 3'b010 || o_id !== 2'd2) begin
            fails++; $display("FAIL bp_hold[%0d]: got v=%b g=%b id=%0d want v=1 g=010 id=2", c, o_valid, o_grey, o_id);
         end
      end
      @(negedge i_clk);
      i_ready = 1'b1;
      #1;
      tests++; if (o_gnt !== 4'b1000) begin fails++; $display("FAIL bp_release_gnt: got %b want 1000", o_gnt); end
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b1 || o_grey !== 3'b100 || o_id !== 2'd3) begin
         fails++; $display("FAIL bp_release_data: got v=%b g=%b id=%0d want v=1 g=100 id=3", o_valid, o_grey, o_id);
      end
      @(negedge i_clk);
      i_req = '0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_enable;
      @(negedge i_clk);
      i_req = 4'b0010; set_bin(1, 3'b110); i_ready = 1'b0;
      #1;
      tests++; if (o_gnt !== 4'b0010) begin fails++; $display("FAIL en_load_gnt: got %b want 0010", o_gnt); end
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b1 || o_grey !== 3'b101) begin fails++; $display("FAIL en_load: got v=%b g=%b want v=1 g=101", o_valid, o_grey); end
      @(negedge i_clk);
      i_en = 1'b0; i_ready = 1'b1;
      #1;
      tests++; if (o_gnt !== 4'b0000) begin fails++; $display("FAIL en_off_gnt: got %b want 0000", o_gnt); end
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL en_drain: got %b want 0", o_valid); end
      @(negedge i_clk);
      #1;
      tests++; if (o_gnt !== 4'b0000) begin fails++; $display("FAIL en_off_idle_gnt: got %b want 0000", o_gnt); end
      @(negedge i_clk);
      i_en = 1'b1;
      #1;
      tests++; if (o_gnt !== 4'b0010) begin fails++; $display("FAIL en_on_gnt: got %b want 0010", o_gnt); end
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b1 || o_id !== 2'd1 || o_grey !== 3'b101) begin
         fails++; $display("FAIL en_on_data: got v=%b g=%b id=%0d want v=1 g=101 id=1", o_valid, o_grey, o_id);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge i_clk);
      i_req = 4'b1111; i_ready = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
      tests++; if (o_grey !== 3'b000 || o_id !== 2'd0) begin fails++; $display("FAIL rst_mid_data: got g=%b id=%0d want g=000 id=0", o_grey, o_id); end
      tests++; if (o_gnt !== 4'b0000) begin fails++; $display("FAIL rst_mid_gnt: got %b want 0000", o_gnt); end
      @(negedge i_clk);
      i_req = '0; i_ready = 1'b1;
      i_rst_n = 1'b1;
   endtask

   task automatic test_round_robin;
      logic [REQS-1:0] exp_gnt;
      logic [ID_W-1:0] exp_id;
      logic [N-1:0] exp_grey;
      set_bin(0, 3'b010); set_bin(2, 3'b110);
      for (int c = 0; c < 4; c++) begin
         exp_gnt = (c % 2 == 0) ? 4'b0001 : 4'b0100;
         exp_id = (c % 2 == 0) ? 2'd0 : 2'd2;
         exp_grey = (c % 2 == 0) ? 3'b011 : 3'b101;
         @(negedge i_clk);
         i_req = 4'b0101;
         #1;
         tests++; if (o_gnt !== exp_gnt) begin fails++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, o_gnt, exp_gnt); end
         @(posedge i_clk); #1;
         tests++; if (o_id !== exp_id || o_grey !== exp_grey || o_valid !== 1'b1) begin
            fails++; $display("FAIL rr_data[%0d]: got v=%b g=%b id=%0d want v=1 g=%b id=%0d", c, o_valid, o_grey, o_id, exp_grey, exp_id);
         end
      end
      @(negedge i_clk);
      i_req = '0;
   endtask

   initial begin
      i_rst_n = 1'b0; i_en = 1'b1; i_ready = 1'b1; i_req = '0; i_bin = '0;
      test_reset;
      test_single;
      test_exhaustive;
      test_backpressure;
      test_enable;
      test_reset_mid;
      test_round_robin;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/grey_encoder_arbiter.md
Name: grey_encoder_arbiter

Overview:
- Shares one Gray-code encoding stage (o = bin ^ (bin >> 1)) among REQS requesters.
- Round-robin arbitration with a one-entry registered output slot, valid/ready backpressure and a requester-ID tag.
- Sits between several producers of binary values (pointers, counters) and a single consumer of Gray values, e.g. a CDC synchroniser bank.

Parameters:
- N, 3, data width of each binary input and of the Gray output.
- REQS, 4, number of requesters (2..16).
- ID_W, 2, width of o_id; must equal ceil(log2(REQS)).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  global enable; when low, no new grants are issued.
- i_req  input  REQS  per-requester request; bit r is held high until granted.
- i_bin  input  REQS*N  flattened binary values; requester r occupies bits [r*N +: N]; must be stable while i_req[r] is high.
- o_gnt  output  REQS  one-hot grant; combinational; the transfer completes at the rising edge where o_gnt[r] is high.
- o_grey  output  N  registered Gray code of the granted value.
- o_id  output  ID_W  registered index of the requester that produced o_grey.
- o_valid  output  1  output slot holds valid data.
- i_ready  input  1  consumer accepts o_grey/o_id at the rising edge where o_valid and i_ready are both high.

Behaviour:
- Reset (async, i_rst_n low): o_valid=0, o_grey=0, o_id=0, RR pointer=REQS-1, so requester 0 has first priority. o_gnt=0 while in reset.
- Reset mid-operation: the pending slot and any grant in flight are discarded. No transfer is counted.
- Slot free condition: free = !o_valid || i_ready.
- Grant condition: grant_ok = i_en && free && |i_req.
- Arbitration:
  - When grant_ok is high, o_gnt selects the first requester with i_req high, scanning from ptr+1 upward modulo REQS.
  - When grant_ok is low, o_gnt=0.
- On a granted edge (one-hot o_gnt, index g):
  - o_grey <= bin_g ^ (bin_g >> 1)
  - o_id <= g
  - o_valid <= 1
  - ptr <= g
- On an edge where the slot is consumed (o_valid && i_ready) with no new grant: o_valid <= 0. o_grey and o_id keep their last values.
- Simultaneous consume and grant: the slot is overwritten by the new value and o_valid stays 1. This gives full throughput of one value per cycle.
- Backpressure: while o_valid && !i_ready, o_grey, o_id and o_valid hold stable, and no grant is issued.
- Latency: a grant at edge k produces o_valid=1 with the data after edge k (one-cycle latency).
- Pointer: updates only on a grant and is unaffected by i_en. Wrap-around: after granting REQS-1, the scan restarts at 0.
- i_en low: an existing o_valid still drains via i_ready. Requests stay pending.
- Arithmetic: pure bitwise encoding, width N, no carry. The MSB of o_grey equals the MSB of bin.
- Requester protocol: a request deasserted before it is granted is simply not served (no error).

Test Plan:
- Reset: assert i_rst_n=0 mid-simulation with o_valid=1 -> o_valid, o_grey and o_id go to 0 immediately, without waiting for a clock edge. o_gnt=0.
- Single requester: i_req=0001, bin0=3'b101, i_ready=1, i_en=1 -> o_gnt=0001 that cycle. Next cycle o_valid=1, o_grey=3'b111, o_id=0.
- Exhaustive encoding with full throughput: requester 1 presents bin 0..7 on consecutive grants with i_ready=1 -> o_grey sequence 000,001,011,010,110,111,101,100, o_valid continuously high, o_id=1.
- Round-robin fairness: i_req=0101 held, bins 3'b010 and 3'b110 -> o_id alternates 0,2,0,2, o_grey alternates 011,101.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles with i_req=1111 -> o_gnt=0, outputs stable. Raise i_ready -> grant issued that same cycle, and o_valid stays 1 with new data.
- Enable gating: drop i_en with a pending slot and i_req=0010 -> slot drains on i_ready, o_valid=0, no grants. Restore i_en -> requester 1 is granted in the next cycle.
